p4_router_ingress_arbiter: RTL

//  - N-channel, packet-atomic round-robin merge of ingress AXIS streams with per-packet user metadata.
//  - Single AXIS stream plus SOP-aligned metadata out, feeding the Vitis Net P4 pipeline wrapper.
//  - Appends source channel ID to metadata so P4 tables can match on ingress port.

---
 rtl/p4_router_ingress_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/p4_router_ingress_arbiter.sv
// Packet-atomic round-robin merge of N AXIS ingress streams into one, tagging SOP metadata
// with the source channel ID. Optional per-channel packet counters: P4_ROUTER_INGRESS_ARB_STATS_EN.
module p4_router_ingress_arbiter #(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned DATA_BYTES    = 8,
    parameter int unsigned IN_META_WIDTH = 16,
    localparam int unsigned CHAN_ID_WIDTH = $clog2(NUM_CHANNELS)
) (
    input  logic                                    clk,
    input  logic                                    aresetn,
    input  logic [NUM_CHANNELS-1:0]                 chan_enable,
    input  logic [NUM_CHANNELS*DATA_BYTES*8-1:0]    in_tdata,
    input  logic [NUM_CHANNELS*DATA_BYTES-1:0]      in_tkeep,
    input  logic [NUM_CHANNELS-1:0]                 in_tlast,
    input  logic [NUM_CHANNELS-1:0]                 in_tvalid,
    output logic [NUM_CHANNELS-1:0]                 in_tready,
    input  logic [NUM_CHANNELS*IN_META_WIDTH-1:0]   in_meta,
    output logic [DATA_BYTES*8-1:0]                 out_tdata,
    output logic [DATA_BYTES-1:0]                   out_tkeep,
    output logic                                    out_tlast,
    output logic                                    out_tvalid,
    input  logic                                    out_tready,
    output logic [IN_META_WIDTH+CHAN_ID_WIDTH-1:0]  out_meta,
    output logic                                    out_meta_valid,
    output logic [NUM_CHANNELS*32-1:0]              pkt_count
);

    localparam int unsigned DW = DATA_BYTES * 8;

    typedef enum logic [0:0] {StIdle, StPass} state_e;

    state_e                    state_q, state_d;
    logic [CHAN_ID_WIDTH-1:0]  grant_q, grant_d;
    logic [CHAN_ID_WIDTH-1:0]  last_grant_q, last_grant_d;
    logic                      sop_q, sop_d;

    logic [NUM_CHANNELS-1:0]   req;
    logic                      found;
    logic [CHAN_ID_WIDTH-1:0]  cand;
    logic                      grant_ready;
    logic                      accept;

    logic [DW-1:0]             sel_data;
    logic [DATA_BYTES-1:0]     sel_keep;
    logic                      sel_last;
    logic [IN_META_WIDTH-1:0]  sel_meta;

    logic [DW-1:0]                            out_tdata_q;
    logic [DATA_BYTES-1:0]                    out_tkeep_q;
    logic                                     out_tlast_q;
    logic                                     out_tvalid_q;
    logic [IN_META_WIDTH+CHAN_ID_WIDTH-1:0]   out_meta_q;
    logic                                     out_meta_valid_q;

    assign req         = in_tvalid & chan_enable;
    assign grant_ready = !out_tvalid_q || out_tready;

    // Search starts one past the last grant so the pointer rotates per packet.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
            if (!found && req[(32'(last_grant_q) + i) % NUM_CHANNELS]) begin
                found = 1'b1;
                cand  = CHAN_ID_WIDTH'((32'(last_grant_q) + i) % NUM_CHANNELS);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_last = 1'b0;
        sel_meta = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_q == CHAN_ID_WIDTH'(i)) begin
                sel_data = in_tdata[i*DW +: DW];
                sel_keep = in_tkeep[i*DATA_BYTES +: DATA_BYTES];
                sel_last = in_tlast[i];
                sel_meta = in_meta[i*IN_META_WIDTH +: IN_META_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sop_d        = sop_q;
        in_tready    = '0;
        accept       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d      = cand;
                    last_grant_d = cand;
                    sop_d        = 1'b1;
                    state_d      = StPass;
                end
            end
            StPass: begin
                in_tready[grant_q] = grant_ready;
                accept             = in_tvalid[grant_q] && grant_ready;
                if (accept) begin
                    sop_d = 1'b0;
                    if (sel_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= CHAN_ID_WIDTH'(NUM_CHANNELS - 1);
            sop_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sop_q        <= sop_d;
        end
    end

    // Metadata is only refreshed on the SOP beat; later beats keep the old value.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_tdata_q      <= '0;
            out_tkeep_q      <= '0;
            out_tlast_q      <= 1'b0;
            out_tvalid_q     <= 1'b0;
            out_meta_q       <= '0;
            out_meta_valid_q <= 1'b0;
        end else if (accept) begin
            out_tdata_q      <= sel_data;
            out_tkeep_q      <= sel_keep;
            out_tlast_q      <= sel_last;
            out_tvalid_q     <= 1'b1;
            out_meta_valid_q <= sop_q;
            if (sop_q) begin
                out_meta_q <= {sel_meta, grant_q};
            end
        end else if (out_tready) begin
            out_tvalid_q     <= 1'b0;
            out_meta_valid_q <= 1'b0;
        end
    end

    assign out_tdata      = out_tdata_q;
    assign out_tkeep      = out_tkeep_q;
    assign out_tlast      = out_tlast_q;
    assign out_tvalid     = out_tvalid_q;
    assign out_meta       = out_meta_q;
    assign out_meta_valid = out_meta_valid_q;

`ifdef P4_ROUTER_INGRESS_ARB_STATS_EN
    logic [31:0] pkt_count_q [NUM_CHANNELS];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                pkt_count_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                if (accept && sel_last && grant_q == CHAN_ID_WIDTH'(i) &&
                    pkt_count_q[i] != 32'hFFFF_FFFF) begin
                    pkt_count_q[i] <= pkt_count_q[i] + 32'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_pkt_count
        assign pkt_count[gi*32 +: 32] = pkt_count_q[gi];
    end
`else
    assign pkt_count = '0;
`endif

endmodule
